sim_spram_array: RTL

SIM_SPRAM_ARRAY -- requirements
Module: sim_spram_array

---
 rtl/sim_spram_array.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sim_spram_array.sv
// Behavioural SPRAM array: LANES x DEPTH_BANKS 16-bit banks with power states,
// nibble-masked writes, POISON fill at power-off and a saturating reject counter.
module sim_spram_array #(
    parameter int unsigned  LANES       = 1,
    parameter int unsigned  DEPTH_BANKS = 1,
    parameter int unsigned  WAKE_CYCLES = 3,
    parameter logic [15:0]  POISON      = 16'hDEAD,
    localparam int unsigned DW          = 16 * LANES,
    localparam int unsigned AW          = 14 + $clog2(DEPTH_BANKS),
    localparam int unsigned MW          = 4 * LANES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [MW-1:0] wmask,
    input  logic          standby,
    input  logic          sleep,
    input  logic          pwr_off,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          ready,
    output logic [7:0]    err_cnt
);

    localparam int unsigned    NWORDS      = DEPTH_BANKS * 16384;
    localparam int unsigned    CW          = 4;
    localparam logic [DW-1:0]  POISON_WORD = {LANES{POISON}};

    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_STBY,
        ST_SLEEP,
        ST_WAKE,
        ST_OFF
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  wcnt_q;
    logic [DW-1:0]  rdata_q;
    logic           rvalid_q;
    logic           ready_q;
    logic [7:0]     err_cnt_q;

    // Words are stored XORed with POISON so zero-initialised storage reads as POISON.
    logic [DW-1:0]  mem_q [NWORDS];

    logic           active;
    logic           acc_rd;
    logic           acc_wr;
    logic           reject;
    logic           wipe;
    logic           going_dark;
    logic [DW-1:0]  cur_word;
    logic [DW-1:0]  merged_d;

    assign active     = (state_q == ST_ACTIVE);
    assign acc_rd     = cs && !we && active;
    assign acc_wr     = cs && we && active;
    assign reject     = cs && !active;
    assign wipe       = pwr_off && (state_q != ST_OFF);
    assign going_dark = (pwr_off && (state_q != ST_OFF)) ||
                        (!pwr_off && sleep && (state_q != ST_SLEEP));

    always_comb begin
        cur_word = mem_q[addr] ^ POISON_WORD;
        merged_d = cur_word;
        for (int n = 0; n < int'(MW); n++) begin
            if (wmask[n]) begin
                merged_d[4*n +: 4] = wdata[4*n +: 4];
            end
        end
    end

    // Storage: power-off wipe wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (wipe) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else if (acc_wr) begin
            mem_q[addr] <= merged_d ^ POISON_WORD;
        end
    end

    // Power-state machine with registered read path and reject counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACTIVE;
            wcnt_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            ready_q   <= 1'b1;
            err_cnt_q <= '0;
        end else begin
            ready_q  <= 1'b0;
            rvalid_q <= acc_rd && !going_dark;

            if (going_dark) begin
                rdata_q <= '0;
            end else if (acc_rd) begin
                rdata_q <= cur_word;
            end

            if (reject && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end

            if (pwr_off) begin
                state_q <= ST_OFF;
            end else if (sleep) begin
                state_q <= ST_SLEEP;
            end else begin
                case (state_q)
                    ST_ACTIVE: begin
                        if (standby) begin
                            state_q <= ST_STBY;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                    ST_STBY: begin
                        if (!standby) begin
                            state_q <= ST_ACTIVE;
                            ready_q <= 1'b1;
                        end
                    end
                    ST_SLEEP, ST_OFF: begin
                        state_q <= ST_WAKE;
                        wcnt_q  <= CW'(WAKE_CYCLES - 1);
                    end
                    ST_WAKE: begin
                        if (wcnt_q == '0) begin
                            state_q <= ST_ACTIVE;
                            ready_q <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_ACTIVE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign ready   = ready_q;
    assign err_cnt = err_cnt_q;

endmodule
